// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: operation encodings, FSM state
// type, default datapath width and a helper that classifies iterative ops.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_DIVU = 3'b011,
        OP_SUB  = 3'b100,
        OP_MUL  = 3'b101,
        OP_SLT  = 3'b110,
        OP_REMU = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // MUL, DIVU and REMU run through the WIDTH-step iterative unit.
    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: unsigned shift-add multiply and unsigned restoring
// division, one bit per clock, WIDTH steps per operation.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_start           load operands and begin (ignored while running)
//   i_mul             1 = multiply, 0 = divide
//   i_a, i_b          multiplier/dividend, multiplicand/divisor
//   o_done            high during the final step
//   o_lo, o_hi        register values after the current step:
//                     MUL {o_hi,o_lo} = product; DIV o_lo = quotient, o_hi = remainder
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_mul,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    r_cnt;
    logic             r_mul;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opd;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_nxt_acc;
    logic [WIDTH-1:0] w_nxt_lo;

    assign w_add   = {1'b0, r_acc} + {1'b0, r_opd};
    assign w_shift = {r_acc, r_lo[WIDTH-1]};
    assign w_ge    = w_shift >= {1'b0, r_opd};
    // When w_ge holds the difference is below the divisor, so WIDTH bits suffice.
    assign w_sub   = w_shift[WIDTH-1:0] - r_opd;

    always_comb begin
        w_nxt_acc = r_acc;
        w_nxt_lo  = r_lo;
        if (r_mul) begin
            if (r_lo[0]) begin
                w_nxt_acc = w_add[WIDTH:1];
                w_nxt_lo  = {w_add[0], r_lo[WIDTH-1:1]};
            end else begin
                w_nxt_acc = {1'b0, r_acc[WIDTH-1:1]};
                w_nxt_lo  = {r_acc[0], r_lo[WIDTH-1:1]};
            end
        end else begin
            // Divisor 0 always "fits": quotient all ones, remainder = dividend.
            if (w_ge) begin
                w_nxt_acc = w_sub;
                w_nxt_lo  = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_nxt_acc = w_shift[WIDTH-1:0];
                w_nxt_lo  = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_mul <= 1'b0;
            r_acc <= '0;
            r_lo  <= '0;
            r_opd <= '0;
        end else if (i_start && (r_cnt == '0)) begin
            r_cnt <= CW'(WIDTH);
            r_mul <= i_mul;
            r_acc <= '0;
            r_lo  <= i_a;
            r_opd <= i_b;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_acc <= w_nxt_acc;
            r_lo  <= w_nxt_lo;
        end
    end

    assign o_done = (r_cnt == CW'(1));
    assign o_lo   = w_nxt_lo;
    assign o_hi   = w_nxt_acc;

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/add/sub/compare, iterative mul/div.
// Valid/ready request and result handshakes; one request in flight.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake (ready only in IDLE)
//   src_a, src_b, op           operands and operation
//   out_valid/out_ready        result handshake
//   result, result_hi          low word, MUL upper word (else 0)
//   zero_flag, ovf_flag, dbz_flag  result==0, ADD/SUB overflow, divide by zero
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | iterative unit running WIDTH steps
// DONE  | result presented, waiting for out_ready
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_flag,
    output logic             ovf_flag,
    output logic             dbz_flag
);

    alu_state_e       r_state;
    logic [2:0]       r_op;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_dbz;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_start;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_slt;
    logic [WIDTH-1:0] w_single_res;
    logic             w_single_ovf;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_lo;
    logic [WIDTH-1:0] w_iter_hi;
    logic [WIDTH-1:0] w_iter_res;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_start  = w_accept && is_iterative(op);

    assign w_sum     = src_a + src_b;
    assign w_diff    = src_a - src_b;
    assign w_add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
    assign w_sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
    assign w_slt     = $signed(src_a) < $signed(src_b);

    always_comb begin
        w_single_res = '0;
        w_single_ovf = 1'b0;
        case (op)
            OP_AND: w_single_res = src_a & src_b;
            OP_OR:  w_single_res = src_a | src_b;
            OP_ADD: begin
                w_single_res = w_sum;
                w_single_ovf = w_add_ovf;
            end
            OP_SUB: begin
                w_single_res = w_diff;
                w_single_ovf = w_sub_ovf;
            end
            OP_SLT: w_single_res = {{(WIDTH-1){1'b0}}, w_slt};
            default: ;
        endcase
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_mul   (op == OP_MUL),
        .i_a     (src_a),
        .i_b     (src_b),
        .o_done  (w_iter_done),
        .o_lo    (w_iter_lo),
        .o_hi    (w_iter_hi)
    );

    // Remainder lives in the accumulator; product low word and quotient in lo.
    assign w_iter_res = (r_op == OP_REMU) ? w_iter_hi : w_iter_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_div_zero  <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op       <= op;
                        r_div_zero <= (src_b == '0);
                        if (is_iterative(op)) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_result    <= w_single_res;
                            r_result_hi <= '0;
                            r_zero      <= (w_single_res == '0);
                            r_ovf       <= w_single_ovf;
                            r_dbz       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_iter_done) begin
                        r_result    <= w_iter_res;
                        r_result_hi <= (r_op == OP_MUL) ? w_iter_hi : '0;
                        r_zero      <= (w_iter_res == '0);
                        r_ovf       <= 1'b0;
                        r_dbz       <= r_div_zero && (r_op != OP_MUL);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero_flag = r_zero;
    assign ovf_flag  = r_ovf;
    assign dbz_flag  = r_dbz;

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu (WIDTH=32): directed cases plus randomized
// requests, compared every cycle against a behavioural model.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero_flag;
    logic         ovf_flag;
    logic         dbz_flag;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero_flag (zero_flag),
        .ovf_flag  (ovf_flag),
        .dbz_flag  (dbz_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         ovf;
        logic         dbz;
    } exp_t;

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint unsigned p;
        e.res = '0; e.hi = '0; e.ovf = 1'b0; e.dbz = 1'b0;
        case (o)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin
                e.res = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b100: begin
                e.res = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b101: begin
                p = 64'(a) * 64'(b);
                e.res = p[31:0];
                e.hi  = p[63:32];
            end
            3'b011: begin
                if (b == 0) begin e.res = '1; e.dbz = 1'b1; end
                else e.res = a / b;
            end
            3'b111: begin
                if (b == 0) begin e.res = a; e.dbz = 1'b1; end
                else e.res = a % b;
            end
            default: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: the model tracks one outstanding request and when its
    // result must appear; every cycle the DUT outputs are checked against it.
    bit   have = 1'b0;
    exp_t cur;
    int   acc_cyc = 0;
    int   lat = 0;

    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 1'b0;
                chk("rst_out_valid", 64'(out_valid), 64'(0));
                chk("rst_result", 64'(result), 64'(0));
                chk("rst_result_hi", 64'(result_hi), 64'(0));
                chk("rst_flags", 64'({zero_flag, ovf_flag, dbz_flag}), 64'(0));
                chk("rst_in_ready", 64'(in_ready), 64'(1));
            end else begin
                chk("in_ready", 64'(in_ready), 64'(!have));
                ev = have && ((cyc - acc_cyc) >= lat);
                chk("out_valid", 64'(out_valid), 64'(ev));
                if (ev) begin
                    chk("result", 64'(result), 64'(cur.res));
                    chk("result_hi", 64'(result_hi), 64'(cur.hi));
                    chk("zero_flag", 64'(zero_flag), 64'(cur.z));
                    chk("ovf_flag", 64'(ovf_flag), 64'(cur.ovf));
                    chk("dbz_flag", 64'(dbz_flag), 64'(cur.dbz));
                    if (out_ready) have = 1'b0;
                end else if (!have && in_valid) begin
                    cur     = model(op, src_a, src_b);
                    lat     = (op == 3'b101 || op == 3'b011 || op == 3'b111) ? W + 1 : 1;
                    acc_cyc = cyc;
                    have    = 1'b1;
                end
            end
        end
    end

    task automatic wait_accept(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 64'(0), 64'(1));
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit noise);
        bit ok;
        int n = 0;
        @(posedge clk); #1;
        op = o; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
        wait_accept(ok);
        if (!ok) begin in_valid = 1'b0; return; end
        @(posedge clk); #1;
        if (!noise) in_valid = 1'b0;
        while (1) begin
            if (noise) begin
                in_valid = 1'b1;
                src_a = $urandom;
                src_b = $urandom;
                op = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 3 * W) begin
                chk("result_timeout", 64'(0), 64'(1));
                in_valid = 1'b0;
                return;
            end
            #1;
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_mul();
        bit ok;
        @(posedge clk); #1;
        op = 3'b101; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; in_valid = 1'b1; out_ready = 1'b1;
        wait_accept(ok);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] edges [6];
        edges[0] = 32'h0000_0000; edges[1] = 32'h0000_0001; edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF; edges[5] = 32'h0000_0007;
        case ($urandom_range(0, 3))
            0: return edges[$urandom_range(0, 5)];
            1: return W'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Pin the model with hand-computed values.
        e = model(3'b010, 32'h7FFF_FFFF, 32'h1);
        chk("pin_add_res", 64'(e.res), 64'h8000_0000);
        chk("pin_add_ovf", 64'({e.ovf, e.z}), 64'b10);
        e = model(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("pin_mul", {e.hi, e.res}, 64'hFFFF_FFFE_0000_0001);
        e = model(3'b011, 32'd100, 32'd7);
        chk("pin_divu", 64'(e.res), 64'd14);
        e = model(3'b111, 32'd100, 32'd7);
        chk("pin_remu", 64'(e.res), 64'd2);
        e = model(3'b011, 32'd5, 32'd0);
        chk("pin_divu_dbz", {31'(0), e.dbz, e.res}, 64'h1_FFFF_FFFF);
        e = model(3'b111, 32'd5, 32'd0);
        chk("pin_remu_dbz", {31'(0), e.dbz, e.res}, 64'h1_0000_0005);
        e = model(3'b110, 32'hFFFF_FFFF, 32'h1);
        chk("pin_slt", 64'(e.res), 64'd1);
        e = model(3'b100, 32'd5, 32'd5);
        chk("pin_sub_zero", 64'({e.z, e.ovf}), 64'b10);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(3'b010, 32'h7FFF_FFFF, 32'h1, 0, 0);
        send(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        send(3'b011, 32'd100, 32'd7, 0, 0);
        send(3'b111, 32'd100, 32'd7, 0, 0);
        send(3'b011, 32'd5, 32'd0, 0, 0);
        send(3'b111, 32'd5, 32'd0, 0, 0);
        send(3'b100, 32'd5, 32'd5, 10, 0);
        reset_mid_mul();
        send(3'b110, 32'hFFFF_FFFF, 32'h1, 0, 0);
        send(3'b101, 32'h0012_3457, 32'h0000_89AB, 1, 1);
        send(3'b011, 32'hDEAD_BEEF, 32'h0000_1234, 0, 1);
        send(3'b100, 32'h8000_0000, 32'h1, 2, 0);
        send(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0);
        send(3'b001, 32'h0000_0000, 32'h0000_0000, 0, 0);

        for (int i = 0; i < 60; i++) begin
            send(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
